// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
// State encoding, sysid word addresses and data width.
package sysid_checker_pkg;

   localparam int SYSID_DW = 32;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_ID  = 3'd1,
      LAT_ID = 3'd2,
      RD_TS  = 3'd3,
      LAT_TS = 3'd4,
      DONE   = 3'd5
   } sysid_state_e;

   function automatic logic is_read_state(input sysid_state_e s);
      return (s == RD_ID) || (s == RD_TS);
   endfunction

   function automatic logic is_busy_state(input sysid_state_e s);
      return (s == RD_ID) || (s == LAT_ID) || (s == RD_TS) || (s == LAT_TS);
   endfunction

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
interface sysid_checker_if;
   import sysid_checker_pkg::*;

   logic                avm_address;
   logic                avm_read;
   logic                avm_waitrequest;
   logic [SYSID_DW-1:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );

endinterface

// File: rtl/sysid_checker_rd_latency.sv
// Read-latency counter: capture strobe READ_LATENCY cycles after an accepted read,
// or in the accept cycle itself when READ_LATENCY is 0.
module sysid_rd_latency #(
   parameter int READ_LATENCY = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic i_accept,
   output logic o_capture
);

   logic [1:0] r_cnt;

   // Down-counter loaded on accept; never leaves zero when latency is 0
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= 2'd0;
      end else if (i_accept) begin
         r_cnt <= 2'(READ_LATENCY);
      end else if (r_cnt != 2'd0) begin
         r_cnt <= r_cnt - 2'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_capture = (READ_LATENCY == 0) ? i_accept : (r_cnt == 2'd1);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and checks them.
// Optional per-read watchdog enabled by defining SYSID_CHECK_TIMEOUT_EN.
module sysid_checker
   import sysid_checker_pkg::*;
#(
   parameter logic [SYSID_DW-1:0] EXPECTED_ID  = 32'd0,
   parameter logic [SYSID_DW-1:0] EXPECTED_TS  = 32'd1339225994,
   parameter int                  READ_LATENCY = 0,
   parameter int                  AUTO_START   = 1
`ifdef SYSID_CHECK_TIMEOUT_EN
   , parameter int                TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   sysid_checker_if.master     avm,
   output logic                busy,
   output logic                done,
   output logic                id_ok,
   output logic                ts_ok,
   output logic [SYSID_DW-1:0] id_value,
   output logic [SYSID_DW-1:0] ts_value,
   output logic                timeout
);

   sysid_state_e        r_state;
   sysid_state_e        w_next;
   logic                r_armed;
   logic                r_read;
   logic                r_addr;
   logic                r_busy;
   logic                r_done;
   logic                r_id_ok;
   logic                r_ts_ok;
   logic [SYSID_DW-1:0] r_id_value;
   logic [SYSID_DW-1:0] r_ts_value;
   logic                w_accept;
   logic                w_capture;
   logic                w_launch;
   logic                w_wd_hit;
   logic                w_cap_id;
   logic                w_cap_ts;
   logic                w_enter_done;

   assign w_accept     = r_read && !avm.avm_waitrequest;
   // r_armed is low only in the first cycle after reset: auto-launch there, ignore start
   assign w_launch     = r_armed ? start : (AUTO_START != 0);
   assign w_cap_id     = w_capture && ((r_state == RD_ID) || (r_state == LAT_ID));
   assign w_cap_ts     = w_capture && ((r_state == RD_TS) || (r_state == LAT_TS));
   assign w_enter_done = (w_next == DONE) && (r_state != DONE);

   sysid_rd_latency #(
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_latency (
      .clock     (clock),
      .reset     (reset),
      .i_accept  (w_accept),
      .o_capture (w_capture)
   );

`ifdef SYSID_CHECK_TIMEOUT_EN
   logic [7:0] r_wd;
   logic       r_timeout;

   // A stall is only fatal when the slave still stalls; an accept in the limit cycle wins
   assign w_wd_hit = is_read_state(r_state) && avm.avm_waitrequest &&
                     (r_wd == 8'(TIMEOUT_CYCLES - 1));

   // Per-read stall watchdog and sticky timeout flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wd      <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         if (is_read_state(w_next) && (w_next != r_state)) begin
            r_wd <= 8'd0;
         end else if (is_read_state(r_state) && avm.avm_waitrequest) begin
            r_wd <= r_wd + 8'd1;
         end else begin
            r_wd <= r_wd;
         end
         if (w_wd_hit) begin
            r_timeout <= 1'b1;
         end else if ((r_state == DONE) && (w_next == RD_ID)) begin
            r_timeout <= 1'b0;
         end else begin
            r_timeout <= r_timeout;
         end
      end
   end

   assign timeout = r_timeout;
`else
   assign w_wd_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_launch) w_next = RD_ID;
            else          w_next = IDLE;
         end
         RD_ID: begin
            if (w_wd_hit)      w_next = DONE;
            else if (w_accept) w_next = w_capture ? RD_TS : LAT_ID;
            else               w_next = RD_ID;
         end
         LAT_ID: begin
            if (w_capture) w_next = RD_TS;
            else           w_next = LAT_ID;
         end
         RD_TS: begin
            if (w_wd_hit)      w_next = DONE;
            else if (w_accept) w_next = w_capture ? DONE : LAT_TS;
            else               w_next = RD_TS;
         end
         LAT_TS: begin
            if (w_capture) w_next = DONE;
            else           w_next = LAT_TS;
         end
         DONE: begin
            if (start) w_next = RD_ID;
            else       w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State, bus strobes and result registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_armed    <= 1'b0;
         r_read     <= 1'b0;
         r_addr     <= SYSID_ADDR_ID;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_id_value <= 32'd0;
         r_ts_value <= 32'd0;
      end else begin
         r_state <= w_next;
         r_armed <= 1'b1;
         r_read  <= is_read_state(w_next);
         r_addr  <= ((w_next == RD_TS) || (w_next == LAT_TS)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
         r_busy  <= is_busy_state(w_next);
         r_done  <= (w_next == DONE);
         if (w_cap_id) r_id_value <= avm.avm_readdata;
         else          r_id_value <= r_id_value;
         if (w_cap_ts) r_ts_value <= avm.avm_readdata;
         else          r_ts_value <= r_ts_value;
         // The ID word is already registered; the TS word is compared as it arrives
         if (w_enter_done) begin
            r_id_ok <= !w_wd_hit && (r_id_value == EXPECTED_ID);
            r_ts_ok <= !w_wd_hit && (avm.avm_readdata == EXPECTED_TS);
         end else if (w_next != DONE) begin
            r_id_ok <= 1'b0;
            r_ts_ok <= 1'b0;
         end else begin
            r_id_ok <= r_id_ok;
            r_ts_ok <= r_ts_ok;
         end
      end
   end

   assign avm.avm_read    = r_read;
   assign avm.avm_address = r_addr;
   assign busy            = r_busy;
   assign done            = r_done;
   assign id_ok           = r_id_ok;
   assign ts_ok           = r_ts_ok;
   assign id_value        = r_id_value;
   assign ts_value        = r_ts_value;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: zero-latency auto-start instance and a
// latency-2 manual-start instance, with a scoreboard of expected results.
module tb_sysid_checker;
   import sysid_checker_pkg::*;

   localparam logic [31:0] EXP_TS = 32'd1339225994;
   localparam logic [31:0] ID1    = 32'hA5A5_0001;

   typedef struct packed {
      logic [31:0] id;
      logic [31:0] ts;
      logic        id_ok;
      logic        ts_ok;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, rst1, start0, start1, wait0, wait1;
   logic [31:0] id_ret0, ts_ret0, id_ret1, ts_ret1;
   logic        busy0, done0, id_ok0, ts_ok0, timeout0;
   logic        busy1, done1, id_ok1, ts_ok1, timeout1;
   logic [31:0] id_value0, ts_value0, id_value1, ts_value1;
   logic        p1_v = 1'b0, p1_a = 1'b0, p2_v = 1'b0, p2_a = 1'b0;

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_cmp = 0;
   int   n_err = 0;

   sysid_checker_if if0 ();
   sysid_checker_if if1 ();

   // Combinational slave for instance 0
   assign if0.avm_waitrequest = wait0;
   assign if0.avm_readdata    = if0.avm_address ? ts_ret0 : id_ret0;

   // Latency-2 slave for instance 1: data valid only two cycles after accept
   always @(posedge clk) begin
      p1_v <= if1.avm_read && !if1.avm_waitrequest;
      p1_a <= if1.avm_address;
      p2_v <= p1_v;
      p2_a <= p1_a;
   end
   assign if1.avm_waitrequest = wait1;
   assign if1.avm_readdata    = p2_v ? (p2_a ? ts_ret1 : id_ret1) : 32'hDEAD_BEEF;

   sysid_checker #(
      .READ_LATENCY (0),
      .AUTO_START   (1)
   ) u_dut0 (
      .clock (clk), .reset (rst0), .start (start0), .avm (if0),
      .busy (busy0), .done (done0), .id_ok (id_ok0), .ts_ok (ts_ok0),
      .id_value (id_value0), .ts_value (ts_value0), .timeout (timeout0)
   );

   sysid_checker #(
      .EXPECTED_ID  (ID1),
      .READ_LATENCY (2),
      .AUTO_START   (0)
   ) u_dut1 (
      .clock (clk), .reset (rst1), .start (start1), .avm (if1),
      .busy (busy1), .done (done1), .id_ok (id_ok1), .ts_ok (ts_ok1),
      .id_value (id_value1), .ts_value (ts_value1), .timeout (timeout1)
   );

`ifdef SYSID_CHECK_TIMEOUT_EN
   logic        rst2;
   logic        busy2, done2, id_ok2, ts_ok2, timeout2;
   logic [31:0] id_value2, ts_value2;
   sysid_checker_if if2 ();
   assign if2.avm_waitrequest = 1'b1;
   assign if2.avm_readdata    = 32'd0;

   sysid_checker #(
      .READ_LATENCY   (0),
      .AUTO_START     (1),
      .TIMEOUT_CYCLES (10)
   ) u_dut2 (
      .clock (clk), .reset (rst2), .start (1'b0), .avm (if2),
      .busy (busy2), .done (done2), .id_ok (id_ok2), .ts_ok (ts_ok2),
      .id_value (id_value2), .ts_value (ts_value2), .timeout (timeout2)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int which, input int budget);
      exp_t e;
      int   i = 0;
      while ((i < budget) && !((which == 1) ? done1 : done0)) begin
         @(negedge clk);
         i++;
      end
      chk("done_rise", (which == 1) ? done1 : done0, 1);
      chk("sb_pending", ((which == 1) ? sb1.size() : sb0.size()) != 0, 1);
      if (((which == 1) ? sb1.size() : sb0.size()) != 0) begin
         e = (which == 1) ? sb1.pop_front() : sb0.pop_front();
         chk("sb_id_value", (which == 1) ? id_value1 : id_value0, e.id);
         chk("sb_ts_value", (which == 1) ? ts_value1 : ts_value0, e.ts);
         chk("sb_id_ok",    (which == 1) ? id_ok1 : id_ok0, e.id_ok);
         chk("sb_ts_ok",    (which == 1) ? ts_ok1 : ts_ok0, e.ts_ok);
         chk("sb_busy",     (which == 1) ? busy1 : busy0, 0);
      end
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
      wait0 = 1'b0; wait1 = 1'b0;
      id_ret0 = 32'd0; ts_ret0 = EXP_TS; id_ret1 = ID1; ts_ret1 = EXP_TS;
`ifdef SYSID_CHECK_TIMEOUT_EN
      rst2 = 1'b1;
`endif
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_read",    if0.avm_read, 0);
      chk("rst_addr",    if0.avm_address, 0);
      chk("rst_busy",    busy0, 0);
      chk("rst_done",    done0, 0);
      chk("rst_id_ok",   id_ok0, 0);
      chk("rst_ts_ok",   ts_ok0, 0);
      chk("rst_idv",     id_value0, 0);
      chk("rst_tsv",     ts_value0, 0);
      chk("rst_timeout", timeout0, 0);

      // Auto-start after reset release, no stalls
      sb0.push_back('{id: 32'd0, ts: EXP_TS, id_ok: 1'b1, ts_ok: 1'b1});
      rst0 = 1'b0;
      @(negedge clk);
      chk("t1_c1_read", if0.avm_read, 1);
      chk("t1_c1_addr", if0.avm_address, 0);
      chk("t1_c1_busy", busy0, 1);
      chk("t1_c1_done", done0, 0);
      @(negedge clk);
      chk("t1_c2_read", if0.avm_read, 1);
      chk("t1_c2_addr", if0.avm_address, 1);
      @(negedge clk);
      chk("t1_c3_done", done0, 1);
      chk("t1_c3_read", if0.avm_read, 0);
      wait_done(0, 1);

      // Restart from DONE with a wrong timestamp; start during RD_TS is ignored
      ts_ret0 = 32'h1234_5678;
      sb0.push_back('{id: 32'd0, ts: 32'h1234_5678, id_ok: 1'b1, ts_ok: 1'b0});
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("t2_done_clr", done0, 0);
      chk("t2_idok_clr", id_ok0, 0);
      chk("t2_read",     if0.avm_read, 1);
      chk("t2_addr",     if0.avm_address, 0);
      chk("t2_tsv_keep", ts_value0, EXP_TS);
      @(negedge clk);
      chk("t2_rdts_addr", if0.avm_address, 1);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done(0, 10);
      @(negedge clk);
      chk("t2_done_hold", done0, 1);
      chk("t2_no_rerun",  if0.avm_read, 0);

      // Manual start, stalled ID read, latency 2
      rst1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_idle_busy", busy1, 0);
      chk("t3_idle_read", if1.avm_read, 0);
      wait1 = 1'b1;
      sb1.push_back('{id: ID1, ts: EXP_TS, id_ok: 1'b1, ts_ok: 1'b1});
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("t3_hold_read", if1.avm_read, 1);
         chk("t3_hold_addr", if1.avm_address, 0);
         @(negedge clk);
      end
      chk("t3_c6_read", if1.avm_read, 1);
      chk("t3_c6_addr", if1.avm_address, 0);
      wait1 = 1'b0;
      @(negedge clk);
      chk("t3_lat_read", if1.avm_read, 0);
      chk("t3_lat_busy", busy1, 1);
      chk("t3_lat_idv1", id_value1, 0);
      @(negedge clk);
      chk("t3_lat_idv2", id_value1, 0);
      @(negedge clk);
      chk("t3_idv_cap", id_value1, ID1);
      chk("t3_ts_read", if1.avm_read, 1);
      chk("t3_ts_addr", if1.avm_address, 1);
      wait_done(1, 10);

      // Reset asserted in LAT_ID discards everything asynchronously
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      chk("t4_in_lat", busy1, 1);
      rst1 = 1'b1;
      #1;
      chk("t4_rst_read", if1.avm_read, 0);
      chk("t4_rst_busy", busy1, 0);
      chk("t4_rst_idv",  id_value1, 0);
      chk("t4_rst_tsv",  ts_value1, 0);
      @(negedge clk);
      rst1 = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("t4_rel_start_ign", busy1, 0);
      repeat (3) @(negedge clk);
      chk("t4_idle_read", if1.avm_read, 0);
      chk("t4_idle_done", done1, 0);
      sb1.push_back('{id: ID1, ts: EXP_TS, id_ok: 1'b1, ts_ok: 1'b1});
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done(1, 12);

`ifdef SYSID_CHECK_TIMEOUT_EN
      begin
         int cyc = 0;
         rst2 = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if2.avm_read) cyc++;
            if (done2) break;
         end
         chk("to_read_cycles", cyc, 10);
         chk("to_timeout", timeout2, 1);
         chk("to_done",    done2, 1);
         chk("to_id_ok",   id_ok2, 0);
         chk("to_ts_ok",   ts_ok2, 0);
      end
`else
      chk("no_timeout0", timeout0, 0);
      chk("no_timeout1", timeout1, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
